// File: rtl/ander_pkg.sv
// Shared types for the AND-stage operand pairer: operand word and credit counter.
package ander_pkg;

    localparam int unsigned ANDER_WIDTH    = 32;
    localparam int unsigned ANDER_CREDIT_W = 4;

    typedef logic [ANDER_WIDTH-1:0]    ander_word_t;
    typedef logic [ANDER_CREDIT_W-1:0] ander_credit_t;

endpackage

// File: rtl/ander_pairer_fifo.sv
// Synchronous operand FIFO with extended-pointer full/empty detection and occupancy count.
module ander_pairer_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_c,
    output logic                       full_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH+1)-1:0] count_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    // Pointers carry one extra wrap bit; arithmetic wraps naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head_c  = mem[rd_ptr[AW-1:0]];
    assign empty_c = (wr_ptr == rd_ptr);
    assign full_c  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count_c = CW'(wr_ptr - rd_ptr);

endmodule

// File: rtl/ander_operand_pairer.sv
// Pairs A/B operand streams into d1/d2 for the AND stage, credit-gated, with delayed res_valid.
// Optional statistics outputs enabled by ANDER_OPERAND_PAIRER_STATS_EN.
module ander_operand_pairer
    import ander_pkg::*;
#(
    parameter int unsigned WIDTH   = ANDER_WIDTH,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CREDITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_valid,
    output logic                       a_ready,
    input  logic [WIDTH-1:0]           a_data,
    input  logic                       b_valid,
    output logic                       b_ready,
    input  logic [WIDTH-1:0]           b_data,
    output logic [WIDTH-1:0]           d1,
    output logic [WIDTH-1:0]           d2,
    output logic                       res_valid,
    input  logic                       credit_ret,
    output logic [$clog2(DEPTH+1)-1:0] a_count,
    output logic [$clog2(DEPTH+1)-1:0] b_count
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
    ,
    output logic [31:0]                pair_cnt,
    output logic [31:0]                stall_cnt,
    output logic                       credit_err
`endif
);

    localparam int unsigned SR_LEN = LATENCY + 1;

    logic                a_push_c;
    logic                b_push_c;
    logic                a_full_c;
    logic                b_full_c;
    logic                a_empty_c;
    logic                b_empty_c;
    logic [WIDTH-1:0]    a_head_c;
    logic [WIDTH-1:0]    b_head_c;
    logic                issue_c;
    logic                ret_ok_c;
    ander_credit_t       credits;
    ander_credit_t       credits_nxt_c;
    logic [SR_LEN-1:0]   issue_sr;

    assign a_ready  = !a_full_c;
    assign b_ready  = !b_full_c;
    assign a_push_c = a_valid && !a_full_c;
    assign b_push_c = b_valid && !b_full_c;

    ander_pairer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push_c),
        .push_data (a_data),
        .pop       (issue_c),
        .head_c    (a_head_c),
        .full_c    (a_full_c),
        .empty_c   (a_empty_c),
        .count_c   (a_count)
    );

    ander_pairer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push_c),
        .push_data (b_data),
        .pop       (issue_c),
        .head_c    (b_head_c),
        .full_c    (b_full_c),
        .empty_c   (b_empty_c),
        .count_c   (b_count)
    );

    assign issue_c  = !a_empty_c && !b_empty_c && (credits != '0);
    // A return while already holding every slot is a sink error and is dropped.
    assign ret_ok_c = credit_ret && (credits != ander_credit_t'(CREDITS));

    always_comb begin
        credits_nxt_c = credits;
        case ({issue_c, ret_ok_c})
            2'b10:   credits_nxt_c = credits - ander_credit_t'(1);
            2'b01:   credits_nxt_c = credits + ander_credit_t'(1);
            default: credits_nxt_c = credits;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits  <= ander_credit_t'(CREDITS);
            d1       <= '0;
            d2       <= '0;
            issue_sr <= '0;
        end else begin
            credits  <= credits_nxt_c;
            issue_sr <= {issue_sr[SR_LEN-2:0], issue_c};
            if (issue_c) begin
                d1 <= a_head_c;
                d2 <= b_head_c;
            end
        end
    end

    // One stage to load d1/d2, LATENCY more for the AND stage to present q.
    assign res_valid = issue_sr[SR_LEN-1];

`ifdef ANDER_OPERAND_PAIRER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_cnt   <= '0;
            stall_cnt  <= '0;
            credit_err <= 1'b0;
        end else begin
            if (issue_c) pair_cnt <= pair_cnt + 32'd1;
            if (!a_empty_c && !b_empty_c && (credits == '0)) stall_cnt <= stall_cnt + 32'd1;
            if (credit_ret && (credits == ander_credit_t'(CREDITS))) credit_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ander_operand_pairer.sv
// Directed bench for ander_operand_pairer; models the AND stage and scoreboards results.
module tb_ander_operand_pairer;
    import ander_pkg::*;

    localparam int unsigned WIDTH   = ANDER_WIDTH;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LATENCY = 1;
    localparam int unsigned CREDITS = 4;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic             a_valid, b_valid, a_ready, b_ready;
    logic [WIDTH-1:0] a_data, b_data, d1, d2;
    logic             res_valid, credit_ret;
    logic [CW-1:0]    a_count, b_count;
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
    logic [31:0]      pair_cnt, stall_cnt;
    logic             credit_err;
`endif

    int               checks = 0;
    int               fails  = 0;
    int               cyc    = 0;
    logic [WIDTH-1:0] exp_a [$];
    logic [WIDTH-1:0] exp_b [$];
    logic [WIDTH-1:0] obs [$];
    int               rv_cyc [$];
    logic [WIDTH-1:0] andq [LATENCY];
    logic [WIDTH-1:0] q_model;

    ander_operand_pairer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY), .CREDITS(CREDITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_data     (a_data),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_data     (b_data),
        .d1         (d1),
        .d2         (d2),
        .res_valid  (res_valid),
        .credit_ret (credit_ret),
        .a_count    (a_count),
        .b_count    (b_count)
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
        ,
        .pair_cnt   (pair_cnt),
        .stall_cnt  (stall_cnt),
        .credit_err (credit_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model of the downstream AND register stage sharing rst.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) andq[i] <= '0;
        end else begin
            andq[0] <= d1 & d2;
            for (int i = 1; i < LATENCY; i++) andq[i] <= andq[i-1];
        end
    end
    assign q_model = andq[LATENCY-1];

    always @(negedge clk) begin
        if (!rst && res_valid) begin
            obs.push_back(q_model);
            rv_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_drive(input logic av, input logic [WIDTH-1:0] ad,
                             input logic bv, input logic [WIDTH-1:0] bd, input logic cr);
        a_valid = av; a_data = ad; b_valid = bv; b_data = bd; credit_ret = cr;
        if (av && a_ready) exp_a.push_back(ad);
        if (bv && b_ready) exp_b.push_back(bd);
        step();
        a_valid = 1'b0; b_valid = 1'b0; credit_ret = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; a_valid = 0; b_valid = 0; a_data = '0; b_data = '0; credit_ret = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (d1 !== '0) begin fails++; $display("FAIL reset_d1 got %h want 0", d1); end
        checks++; if (d2 !== '0) begin fails++; $display("FAIL reset_d2 got %h want 0", d2); end
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        checks++; if ({a_count, b_count} !== '0) begin fails++; $display("FAIL reset_counts got %0d/%0d want 0/0", a_count, b_count); end
        checks++; if ({a_ready, b_ready} !== 2'b11) begin fails++; $display("FAIL reset_ready got %b%b want 11", a_ready, b_ready); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_pairing();
        logic [WIDTH-1:0] ea, eb;
        cyc_drive(1'b1, 32'hFFFF0000, 1'b1, 32'h0F0F0F0F, 1'b0);
        checks++; if (d1 !== '0) begin fails++; $display("FAIL pair_early_d1 got %h want 0", d1); end
        step();
        checks++; if (d1 !== 32'hFFFF0000) begin fails++; $display("FAIL pair_d1 got %h want ffff0000", d1); end
        checks++; if (d2 !== 32'h0F0F0F0F) begin fails++; $display("FAIL pair_d2 got %h want 0f0f0f0f", d2); end
        for (int i = 1; i <= LATENCY; i++) begin
            checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL pair_rv_early got %b want 0", res_valid); end
            step();
        end
        checks++; if (res_valid !== 1'b1) begin fails++; $display("FAIL pair_rv got %b want 1", res_valid); end
        checks++; if (q_model !== 32'h0F0F0000) begin fails++; $display("FAIL pair_q got %h want 0f0f0000", q_model); end
        step();
        checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL pair_rv_after got %b want 0", res_valid); end
        checks++; if (obs.size() != 1) begin fails++; $display("FAIL pair_obs_count got %0d want 1", obs.size()); end
        while (obs.size() > 0 && exp_a.size() > 0 && exp_b.size() > 0) begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks++; if (obs[0] !== (ea & eb)) begin fails++; $display("FAIL pair_result got %h want %h", obs[0], ea & eb); end
            void'(obs.pop_front());
        end
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_skew();
        logic [WIDTH-1:0] ea, eb;
        rv_cyc.delete();
        for (int i = 0; i < 4; i++) cyc_drive(1'b1, 32'hA5A50000 | WIDTH'(i + 1), 1'b0, '0, 1'b0);
        checks++; if (a_ready !== 1'b0) begin fails++; $display("FAIL skew_a_ready got %b want 0", a_ready); end
        cyc_drive(1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0);
        checks++; if (a_count !== CW'(4)) begin fails++; $display("FAIL skew_a_count got %0d want 4", a_count); end
        checks++; if (d1 !== 32'hFFFF0000) begin fails++; $display("FAIL skew_no_issue got %h want ffff0000", d1); end
        for (int i = 0; i < 4; i++) cyc_drive(1'b0, '0, 1'b1, 32'h0FF0F00F ^ WIDTH'(i << 4), 1'b0);
        repeat (LATENCY + 4) step();
        checks++; if (obs.size() != 4) begin fails++; $display("FAIL skew_obs_count got %0d want 4", obs.size()); end
        for (int i = 0; i + 1 < rv_cyc.size(); i++) begin
            checks++; if (rv_cyc[i+1] != rv_cyc[i] + 1) begin fails++; $display("FAIL skew_b2b got gap %0d want 1", rv_cyc[i+1] - rv_cyc[i]); end
        end
        while (obs.size() > 0 && exp_a.size() > 0 && exp_b.size() > 0) begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks++; if (obs[0] !== (ea & eb)) begin fails++; $display("FAIL skew_result got %h want %h", obs[0], ea & eb); end
            void'(obs.pop_front());
        end
        for (int i = 0; i < 4; i++) cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_credits();
        logic [WIDTH-1:0] ea, eb;
        for (int i = 0; i < 6; i++) cyc_drive(1'b1, 32'h10000000 + WIDTH'(i), 1'b1, 32'hF0F0F0F0 - WIDTH'(i), 1'b0);
        repeat (6) step();
        checks++; if (obs.size() != 4) begin fails++; $display("FAIL credit_issues got %0d want 4", obs.size()); end
        checks++; if ({a_count, b_count} !== {CW'(2), CW'(2)}) begin fails++; $display("FAIL credit_held got %0d/%0d want 2/2", a_count, b_count); end
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (5) step();
        checks++; if (obs.size() != 5) begin fails++; $display("FAIL credit_one_more got %0d want 5", obs.size()); end
        checks++; if (a_count !== CW'(1)) begin fails++; $display("FAIL credit_after_ret got %0d want 1", a_count); end
        while (obs.size() > 0 && exp_a.size() > 0 && exp_b.size() > 0) begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks++; if (obs[0] !== (ea & eb)) begin fails++; $display("FAIL credit_result got %h want %h", obs[0], ea & eb); end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_reset_mid();
        cyc_drive(1'b1, 32'h11111111, 1'b1, 32'h22222222, 1'b0);
        cyc_drive(1'b1, 32'h33333333, 1'b0, '0, 1'b0);
        checks++; if ({a_count, b_count} !== {CW'(3), CW'(2)}) begin fails++; $display("FAIL rstmid_pre got %0d/%0d want 3/2", a_count, b_count); end
        rst = 1'b1;
        #1;
        checks++; if ({a_count, b_count} !== '0) begin fails++; $display("FAIL rstmid_counts got %0d/%0d want 0/0", a_count, b_count); end
        checks++; if ({d1, d2} !== '0) begin fails++; $display("FAIL rstmid_d got %h/%h want 0/0", d1, d2); end
        step(); step();
        rst = 1'b0;
        exp_a.delete(); exp_b.delete(); obs.delete();
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rstmid_rv cycle %0d got %b want 0", i, res_valid); end
        end
    endtask

    task automatic test_concurrency();
        logic [WIDTH-1:0] ea, eb;
        cyc_drive(1'b1, 32'hCAFE0001, 1'b1, 32'hFFFF00FF, 1'b0);
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b0);
        cyc_drive(1'b1, 32'hCAFE0002, 1'b1, 32'h0000FFFF, 1'b0);
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 4; i++) cyc_drive(1'b1, 32'h12340000 + WIDTH'(i), 1'b1, 32'hFF00FF00 | WIDTH'(i), 1'b0);
        repeat (6) step();
        checks++; if (obs.size() != 5) begin fails++; $display("FAIL conc_issues got %0d want 5", obs.size()); end
        checks++; if (a_count !== CW'(1)) begin fails++; $display("FAIL conc_held got %0d want 1", a_count); end
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) step();
        for (int i = 0; i < 4; i++) cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
        checks++; if (credit_err !== 1'b0) begin fails++; $display("FAIL conc_err_clear got %b want 0", credit_err); end
`endif
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
        checks++; if (credit_err !== 1'b1) begin fails++; $display("FAIL conc_err_set got %b want 1", credit_err); end
`endif
        for (int i = 0; i < 5; i++) cyc_drive(1'b1, 32'h5A5A5A00 + WIDTH'(i), 1'b1, 32'h0FFFFFF0 - WIDTH'(i), 1'b0);
        repeat (6) step();
        checks++; if (obs.size() != 10) begin fails++; $display("FAIL conc_saturate got %0d want 10", obs.size()); end
        checks++; if (a_count !== CW'(1)) begin fails++; $display("FAIL conc_sat_held got %0d want 1", a_count); end
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
        checks++; if (pair_cnt !== 32'd10) begin fails++; $display("FAIL conc_pair_cnt got %0d want 10", pair_cnt); end
`endif
        while (obs.size() > 0 && exp_a.size() > 0 && exp_b.size() > 0) begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks++; if (obs[0] !== (ea & eb)) begin fails++; $display("FAIL conc_result got %h want %h", obs[0], ea & eb); end
            void'(obs.pop_front());
        end
    endtask

    task automatic test_wrap();
        logic [WIDTH-1:0] ea, eb, ad, bd;
        logic             av, bv;
        int               na, nb, guard;
        na = 0; nb = 0; guard = 0;
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
        cyc_drive(1'b0, '0, 1'b0, '0, 1'b1);
        while ((na < 20 || nb < 20) && guard < 600) begin
            av = (na < 20) && ($urandom_range(0, 2) != 0);
            bv = (nb < 20) && ($urandom_range(0, 2) != 0);
            ad = WIDTH'($urandom);
            bd = WIDTH'($urandom);
            if (av && a_ready) na++;
            if (bv && b_ready) nb++;
            cyc_drive(av, ad, bv, bd, res_valid);
            guard++;
        end
        checks++; if (na != 20 || nb != 20) begin fails++; $display("FAIL wrap_push_timeout got %0d/%0d want 20/20", na, nb); end
        guard = 0;
        while (obs.size() < 21 && guard < 200) begin
            cyc_drive(1'b0, '0, 1'b0, '0, res_valid);
            guard++;
        end
        repeat (4) cyc_drive(1'b0, '0, 1'b0, '0, res_valid);
        checks++; if (obs.size() != 21) begin fails++; $display("FAIL wrap_count got %0d want 21", obs.size()); end
        while (obs.size() > 0 && exp_a.size() > 0 && exp_b.size() > 0) begin
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks++; if (obs[0] !== (ea & eb)) begin fails++; $display("FAIL wrap_result got %h want %h", obs[0], ea & eb); end
            void'(obs.pop_front());
        end
        checks++; if (exp_a.size() != 0 || exp_b.size() != 0) begin fails++; $display("FAIL wrap_leftover got %0d/%0d want 0/0", exp_a.size(), exp_b.size()); end
`ifdef ANDER_OPERAND_PAIRER_STATS_EN
        checks++; if (pair_cnt !== 32'd31) begin fails++; $display("FAIL wrap_pair_cnt got %0d want 31", pair_cnt); end
`endif
    endtask

    initial begin
        test_reset();
        test_pairing();
        test_skew();
        test_credits();
        test_reset_mid();
        test_concurrency();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
